// File: rtl/nibble_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_if
// Description : Operand/result handshake and external 4-bit adder bus for
//               nibble_serial_adder. Adds the sub signal when
//               NIBBLE_SERIAL_ADDER_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic                   c_in;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic                   sub;
`endif
    logic [3:0]             add_a;
    logic [3:0]             add_b;
    logic                   add_cin;
    logic [3:0]             add_sum;
    logic                   add_cout;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*NIBBLES-1:0]   sum;
    logic                   c_out;
    logic                   busy;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    modport slave (
        input  in_valid, a, b, c_in, sub, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, sum, c_out, busy
    );
    modport master (
        output in_valid, a, b, c_in, sub, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, sum, c_out, busy
    );
`else
    modport slave (
        input  in_valid, a, b, c_in, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, sum, c_out, busy
    );
    modport master (
        output in_valid, a, b, c_in, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, sum, c_out, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Adds two NIBBLES*4-bit operands one nibble per cycle through an
//               external combinational 4-bit adder. Optional subtract mode is
//               enabled by the NIBBLE_SERIAL_ADDER_SUB_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    nibble_serial_adder_if.slave    bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [IW-1:0]  r_idx;
    logic [W-1:0]   r_a_sh;
    logic [W-1:0]   r_b_sh;
    logic [W-1:0]   r_sum;
    logic [3:0]     r_add_a;
    logic [3:0]     r_add_b;
    logic           r_carry;
    logic           r_c_out;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;

    logic [W-1:0]   w_b_cap;
    logic           w_cin_cap;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + 1
    assign w_b_cap   = bus.sub ? ~bus.b : bus.b;
    assign w_cin_cap = bus.sub ? 1'b1   : bus.c_in;
`else
    assign w_b_cap   = bus.b;
    assign w_cin_cap = bus.c_in;
`endif

    // Adder operands are pre-loaded one cycle ahead from shift registers so the
    // slice for index i is already on add_a/add_b when RUN is at index i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum       <= '0;
            r_add_a     <= 4'h0;
            r_add_b     <= 4'h0;
            r_carry     <= 1'b0;
            r_c_out     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh     <= bus.a >> 4;
                        r_b_sh     <= w_b_cap >> 4;
                        r_add_a    <= bus.a[3:0];
                        r_add_b    <= w_b_cap[3:0];
                        r_carry    <= w_cin_cap;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= bus.add_sum;
                    if (r_idx == IW'(NIBBLES - 1)) begin
                        r_c_out     <= bus.add_cout;
                        r_add_a     <= 4'h0;
                        r_add_b     <= 4'h0;
                        r_carry     <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_add_a <= r_a_sh[3:0];
                        r_add_b <= r_b_sh[3:0];
                        r_a_sh  <= r_a_sh >> 4;
                        r_b_sh  <= r_b_sh >> 4;
                        r_carry <= bus.add_cout;
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.c_out     = r_c_out;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.add_cin   = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder
// Description : Self-checking bench for nibble_serial_adder with a behavioural
//               external 4-bit adder and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_adder_if #(.NIBBLES(N)) bus ();

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External combinational 4-bit adder
    always_comb begin
        {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'h0, bus.add_cin};
    end

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   ov_seen = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] es, input logic ec);
        exp_t e;
        e.sum  = es;
        e.cout = ec;
        sb.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec);
        int t;
        t = 0;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 50) begin
            step();
            t++;
        end
        if (!bus.in_ready) timeout("send");
        push_exp(es, ec);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || !bus.in_ready) && t < 200) begin
            step();
            t++;
        end
        if (sb.size() != 0 || !bus.in_ready) timeout("drain");
    endtask

    // Scoreboard: every accepted result must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            ov_seen++;
            if (bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum %0h with no pending request", bus.sum);
                end else begin
                    e = sb.pop_front();
                    check("sum", 32'(bus.sum), 32'(e.sum));
                    check("c_out", 32'(bus.c_out), 32'(e.cout));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   lat;
        int   n_acc;
        int   acc_cyc[2];
        logic [W-1:0] held;

        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_sum", 32'(bus.sum), 0);
        check("rst_c_out", 32'(bus.c_out), 0);
        check("rst_add_a", 32'(bus.add_a), 0);
        rst_n = 1'b1;
        step();

        // Table vectors, then random ones checked against a+b+c_in
        for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic [W:0]   r;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            r  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            send(ra, rb, rc, r[W-1:0], r[W]);
        end
        drain();

        // Latency: accept edge counts as 1, out_valid after N more edges
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.c_in = 1'b0; bus.in_valid = 1'b1;
        push_exp(16'h0000, 1'b1);
        step();
        lat = 1;
        bus.in_valid = 1'b0;
        check("run_busy", 32'(bus.busy), 1);
        check("run_in_ready", 32'(bus.in_ready), 0);
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), N + 1);
        drain();

        // Nibble slices presented to the external adder, LSB first
        bus.a = 16'h1234; bus.b = 16'h4321; bus.c_in = 1'b1; bus.in_valid = 1'b1;
        push_exp(16'h5556, 1'b0);
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("add_a_seq", 32'(bus.add_a), 32'(4 - k));
            check("add_b_seq", 32'(bus.add_b), 32'(k + 1));
            if (k == 0) check("add_cin_first", 32'(bus.add_cin), 1);
            step();
        end
        check("add_a_done", 32'(bus.add_a), 0);
        check("add_cin_done", 32'(bus.add_cin), 0);
        drain();

        // Stall in DONE with in_valid asserted; the new operand must be ignored
        bus.out_ready = 1'b0;
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.c_in = 1'b0; bus.in_valid = 1'b1;
        push_exp(16'h0000, 1'b1);
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!bus.out_valid) timeout("stall_out_valid");
        held = bus.sum;
        bus.a = 16'h2222; bus.b = 16'h2222; bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("stall_out_valid", 32'(bus.out_valid), 1);
            check("stall_in_ready", 32'(bus.in_ready), 0);
            check("stall_sum", 32'(bus.sum), 32'(held));
            check("stall_c_out", 32'(bus.c_out), 1);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("post_hs_in_ready", 32'(bus.in_ready), 1);
        check("post_hs_out_valid", 32'(bus.out_valid), 0);
        step();
        check("ignored_req_busy", 32'(bus.busy), 0);
        drain();

        // Back-to-back requests with in_valid held high
        n_acc = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        bus.a = 16'h0101; bus.b = 16'h0202; bus.c_in = 1'b0; bus.in_valid = 1'b1;
        for (int c = 0; c < 40 && n_acc < 2; c++) begin
            if (bus.in_ready) begin
                acc_cyc[n_acc] = c;
                if (n_acc == 0) push_exp(16'h0303, 1'b0);
                else            push_exp(16'h0011, 1'b1);
                n_acc++;
            end
            step();
            if (n_acc == 1) begin
                bus.a = 16'hF00F; bus.b = 16'h1001; bus.c_in = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts", 32'(n_acc), 2);
        check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), N + 2);
        drain();

        // Reset while RUN is at index 2: no partial result may appear
        ov_seen = 0;
        bus.a = 16'h1111; bus.b = 16'h2222; bus.c_in = 1'b0; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum", 32'(bus.sum), 0);
        check("mid_rst_c_out", 32'(bus.c_out), 0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 1);
        check("mid_rst_add_a", 32'(bus.add_a), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) step();
        check("no_out_valid_after_rst", 32'(ov_seen), 0);
        check("idle_after_rst", 32'(bus.in_ready), 1);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.sub = 1'b1;
        send(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        bus.sub = 1'b0;
        drain();
`endif

        drain();
        repeat (5) step();
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
